// File: rtl/stage_if.sv
// -----------------------------------------------------------------------------
// stage_if : instruction-fetch stage of the 5-stage RISC-V pipeline.
//
// Owns the PC, fetches one instruction at a time from instruction memory over
// a valid/ready request/response handshake and drives the IF/ID pipeline
// register consumed by the decode stage. At most one fetch is outstanding;
// the response of a fetch squashed by a redirect is accepted and discarded.
//
// Build option:
//   RISCV_IF_SKID_EN  - when defined, a one-entry skid buffer catches a
//                       response that arrives during a stall (state S_HOLD)
//                       so memory is never back-pressured in S_WAIT.
//                       When undefined, the response is held off by
//                       imem_rready until the stall clears.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   pc_sel, pc_imm             redirect request and target from ID
//   IF_flush                   squash IF/ID contents
//   stall                      hold PC-visible state and IF/ID
//   imem_req/addr/ready        fetch request channel
//   imem_rvalid/rdata/rready   fetch response channel
//   IF_ID_pc/inst/rs1/rs2      IF/ID pipeline register
//   IF_ID_valid                IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module stage_if #(
   parameter int                     PC_WIDTH       = 32,
   parameter int                     INST_WIDTH     = 32,
   parameter int                     REG_ADDR_WIDTH = 5,
   parameter logic [PC_WIDTH-1:0]    RESET_PC       = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      pc_sel,
   input  logic [PC_WIDTH-1:0]       pc_imm,
   input  logic                      IF_flush,
   input  logic                      stall,
   output logic                      imem_req,
   output logic [PC_WIDTH-1:0]       imem_addr,
   input  logic                      imem_ready,
   input  logic                      imem_rvalid,
   input  logic [INST_WIDTH-1:0]     imem_rdata,
   output logic                      imem_rready,
   output logic [PC_WIDTH-1:0]       IF_ID_pc,
   output logic [INST_WIDTH-1:0]     IF_ID_inst,
   output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
   output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
   output logic                      IF_ID_valid
);

   localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   state_e                    state_q;
   logic [PC_WIDTH-1:0]       pc_q;
   logic [PC_WIDTH-1:0]       fetch_pc_q;   // address of the fetch in flight / buffered
   logic                      kill_q;       // in-flight fetch has been squashed
   logic [PC_WIDTH-1:0]       if_id_pc_q;
   logic [INST_WIDTH-1:0]     if_id_inst_q;
   logic [REG_ADDR_WIDTH-1:0] if_id_rs1_q;
   logic [REG_ADDR_WIDTH-1:0] if_id_rs2_q;
   logic                      if_id_valid_q;

   logic                      redirect_s;
   logic                      flush_s;
   logic                      rsp_hs_s;
   logic                      rsp_load_s;
   logic                      hold_load_s;
   logic                      outstanding_s;
   logic [PC_WIDTH-1:0]       fetch_addr_s;
   logic [INST_WIDTH-1:0]     ld_inst_s;
   logic                      rready_s;

`ifdef RISCV_IF_SKID_EN
   logic [INST_WIDTH-1:0]     buf_inst_q;
`endif

   // A stalled pipeline ignores redirect and flush requests from ID.
   assign redirect_s   = pc_sel && !stall;
   assign flush_s      = IF_flush && !pc_sel && !stall;
   assign fetch_addr_s = {pc_q[PC_WIDTH-1:2], 2'b00};
   assign rsp_hs_s     = imem_rvalid && rready_s;
   assign rsp_load_s   = (state_q == S_WAIT) && rsp_hs_s && !kill_q && !stall;

   // A fetch still needs squashing on redirect if it is accepted this cycle or
   // is waiting and not answered this cycle; a response consumed in the same
   // cycle as the redirect leaves nothing to kill.
   assign outstanding_s = ((state_q == S_REQ) && imem_ready) ||
                          ((state_q == S_WAIT) && !rsp_hs_s);

`ifdef RISCV_IF_SKID_EN
   assign hold_load_s = (state_q == S_HOLD) && !stall;
   assign ld_inst_s   = hold_load_s ? buf_inst_q : imem_rdata;
`else
   assign hold_load_s = 1'b0;
   assign ld_inst_s   = imem_rdata;
`endif

   // Response-channel ready: only while waiting for a fetch.
   always_comb begin
      rready_s = 1'b0;
      if (reset) begin
         rready_s = 1'b0;
      end else if (state_q == S_WAIT) begin
`ifdef RISCV_IF_SKID_EN
         rready_s = 1'b1;
`else
         // Back-pressure a live response during a stall; killed ones drain.
         rready_s = !stall || kill_q;
`endif
      end else begin
         rready_s = 1'b0;
      end
   end

   assign imem_req    = (state_q == S_REQ) && !reset;
   assign imem_addr   = fetch_addr_s;
   assign imem_rready = rready_s;

   // Fetch FSM, PC, kill flag and IF/ID register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_PC;
         fetch_pc_q    <= '0;
         kill_q        <= 1'b0;
         if_id_pc_q    <= '0;
         if_id_inst_q  <= NOP;
         if_id_rs1_q   <= '0;
         if_id_rs2_q   <= '0;
         if_id_valid_q <= 1'b0;
`ifdef RISCV_IF_SKID_EN
         buf_inst_q    <= NOP;
`endif
      end else begin
         case (state_q)
            S_REQ: begin
               if (imem_ready) begin
                  pc_q       <= pc_q + PC_WIDTH'(4);
                  fetch_pc_q <= fetch_addr_s;
                  state_q    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (rsp_hs_s) begin
                  state_q <= S_REQ;
                  if (kill_q) begin
                     kill_q <= 1'b0;
                  end
`ifdef RISCV_IF_SKID_EN
                  else if (stall) begin
                     buf_inst_q <= imem_rdata;
                     state_q    <= S_HOLD;
                  end
`endif
               end
            end
`ifdef RISCV_IF_SKID_EN
            S_HOLD: begin
               // Leaving S_HOLD either loads IF/ID or, on redirect, drops the buffer.
               if (!stall) begin
                  state_q <= S_REQ;
               end
            end
`endif
            default: begin
               state_q <= S_REQ;
            end
         endcase

         // Redirect wins over the +4 update above.
         if (redirect_s) begin
            pc_q <= pc_imm;
            if (outstanding_s) begin
               kill_q <= 1'b1;
            end
         end

         if (stall) begin
            if_id_valid_q <= if_id_valid_q;
         end else if (redirect_s || flush_s) begin
            if_id_pc_q    <= '0;
            if_id_inst_q  <= NOP;
            if_id_rs1_q   <= '0;
            if_id_rs2_q   <= '0;
            if_id_valid_q <= 1'b0;
         end else if (rsp_load_s || hold_load_s) begin
            if_id_pc_q    <= fetch_pc_q;
            if_id_inst_q  <= ld_inst_s;
            if_id_rs1_q   <= ld_inst_s[19:15];
            if_id_rs2_q   <= ld_inst_s[24:20];
            if_id_valid_q <= 1'b1;
         end else begin
            if_id_valid_q <= if_id_valid_q;
         end
      end
   end

   assign IF_ID_pc    = if_id_pc_q;
   assign IF_ID_inst  = if_id_inst_q;
   assign IF_ID_rs1   = if_id_rs1_q;
   assign IF_ID_rs2   = if_id_rs2_q;
   assign IF_ID_valid = if_id_valid_q;

endmodule

// File: tb/tb_stage_if.sv
// -----------------------------------------------------------------------------
// tb_stage_if : self-checking bench for stage_if.
// A transaction-level reference (next fetch address, busy/killed flags,
// optional skid entry, expected IF/ID contents) plus a small memory model
// driving the response channel. Directed scenarios first, then random traffic.
// -----------------------------------------------------------------------------
module tb_stage_if;

`ifdef RISCV_IF_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset, pc_sel, IF_flush, stall;
   logic [31:0] pc_imm;
   logic        imem_req, imem_ready, imem_rvalid, imem_rready;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] IF_ID_pc, IF_ID_inst;
   logic [4:0]  IF_ID_rs1, IF_ID_rs2;
   logic        IF_ID_valid;

   always #5 clk = ~clk;

   stage_if dut (
      .clk(clk), .reset(reset), .pc_sel(pc_sel), .pc_imm(pc_imm),
      .IF_flush(IF_flush), .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_rready(imem_rready),
      .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst), .IF_ID_rs1(IF_ID_rs1),
      .IF_ID_rs2(IF_ID_rs2), .IF_ID_valid(IF_ID_valid)
   );

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;

   // reference state
   logic [31:0] m_pc, m_fetch, m_buf_inst;
   logic        m_busy, m_kill, m_buf;
   logic [31:0] e_pc, e_inst;
   logic        e_valid;
   // memory model
   logic        mem_pend;
   int          mem_delay;
   logic [31:0] mem_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_fetch = 32'h0; m_buf_inst = NOP;
      m_busy = 1'b0; m_kill = 1'b0; m_buf = 1'b0;
      e_pc = 32'h0; e_inst = NOP; e_valid = 1'b0;
      mem_pend = 1'b0; mem_delay = 0; mem_data = 32'h0;
   endtask

   // One clock cycle: drive inputs, check outputs, advance reference at the edge.
   task automatic cyc(input logic rst, input logic sel, input logic [31:0] imm,
                      input logic fl, input logic st, input logic rdy,
                      input int lat, input logic [31:0] dat);
      logic e_req, e_rready, acc, hs, redir, flsh, ld, busy_nxt;
      logic [31:0] e_addr, ld_pc, ld_inst, rd;
      reset = rst; pc_sel = sel; pc_imm = imm; IF_flush = fl; stall = st; imem_ready = rdy;
      imem_rvalid = mem_pend && (mem_delay == 0);
      imem_rdata  = imem_rvalid ? mem_data : $urandom;
      e_req    = !rst && !m_busy && !m_buf;
      e_addr   = {m_pc[31:2], 2'b00};
      e_rready = !rst && m_busy && (SKID || !st || m_kill);
      #1;
      chk("imem_req", 32'(imem_req), 32'(e_req));
      if (e_req) chk("imem_addr", imem_addr, e_addr);
      chk("imem_rready", 32'(imem_rready), 32'(e_rready));
      chk("IF_ID_pc", IF_ID_pc, e_pc);
      chk("IF_ID_inst", IF_ID_inst, e_inst);
      chk("IF_ID_rs1", 32'(IF_ID_rs1), 32'(e_inst[19:15]));
      chk("IF_ID_rs2", 32'(IF_ID_rs2), 32'(e_inst[24:20]));
      chk("IF_ID_valid", 32'(IF_ID_valid), 32'(e_valid));
      rd = imem_rdata;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         acc   = e_req && rdy;
         hs    = imem_rvalid && e_rready;
         redir = sel && !st;
         flsh  = fl && !sel && !st;
         ld = 1'b0; ld_pc = m_fetch; ld_inst = NOP;
         if (m_buf && !st) begin
            ld = 1'b1; ld_inst = m_buf_inst; m_buf = 1'b0;
         end
         if (hs) begin
            if (m_kill) m_kill = 1'b0;
            else if (st) begin m_buf = 1'b1; m_buf_inst = rd; end
            else begin ld = 1'b1; ld_inst = rd; end
         end
         busy_nxt = acc || (m_busy && !hs);
         m_busy = busy_nxt;
         if (acc) begin m_fetch = e_addr; m_pc = m_pc + 32'd4; end
         if (redir) begin
            m_pc = imm;
            if (busy_nxt) m_kill = 1'b1;
            m_buf = 1'b0;
         end
         if (!st) begin
            if (redir || flsh) begin
               e_pc = 32'h0; e_inst = NOP; e_valid = 1'b0;
            end else if (ld) begin
               e_pc = ld_pc; e_inst = ld_inst; e_valid = 1'b1;
            end
         end
         // memory side
         if (hs) mem_pend = 1'b0;
         else if (mem_pend && mem_delay > 0) mem_delay--;
         if (acc) begin mem_pend = 1'b1; mem_delay = lat; mem_data = dat; end
      end
      @(negedge clk);
   endtask

   // Idle until the stage is ready to issue a request (bounded).
   task automatic to_req();
      for (int i = 0; i < 8; i++) begin
         if (m_busy || m_buf) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
      end
   endtask

   initial begin
      model_reset();
      reset = 1'b1; pc_sel = 1'b0; pc_imm = 32'h0; IF_flush = 1'b0; stall = 1'b0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      @(posedge clk);
      @(negedge clk);

      // reset values, then zero-wait fetches of addi x1,x0,10
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 32'h00A00093);
      chk("seq_pc_after_4", IF_ID_pc, 32'h0000_000C);
      chk("seq_valid", 32'(IF_ID_valid), 32'd1);

      // redirect while waiting on 0x10: response discarded, next fetch at 0x40
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1, 32'h00A00093);
      cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 0, 32'h0);
      chk("redir_valid", 32'(IF_ID_valid), 32'd0);
      chk("redir_inst", IF_ID_inst, NOP);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 32'h00A00093);

      // stall three cycles while add x2,x1,x2 response is pending
      to_req();
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 32'h00208133);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
      chk("stall_inst", IF_ID_inst, 32'h00208133);
      chk("stall_rs1", 32'(IF_ID_rs1), 32'd1);
      chk("stall_rs2", 32'(IF_ID_rs2), 32'd2);

      // stall with pc_sel: redirect ignored
      to_req();
      cyc(1'b0, 1'b1, 32'h80, 1'b0, 1'b1, 1'b1, 0, 32'h00A00093);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 32'h00A00093);

      // flush without redirect
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 0, 32'h00A00093);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 32'h00A00093);

      // memory not ready for four cycles
      to_req();
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 32'h00A00093);

      // reset while waiting for a response
      to_req();
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2, 32'h00A00093);
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
      chk("rst_valid", 32'(IF_ID_valid), 32'd0);
      chk("rst_pc", IF_ID_pc, 32'h0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 32'h00A00093);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(199) == 0),
             ($urandom_range(7) == 0), $urandom,
             ($urandom_range(9) == 0),
             ($urandom_range(3) == 0),
             ($urandom_range(2) != 0),
             int'($urandom_range(3)), $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
